fight_health_tracker: RTL and testbench

- Round/health bookkeeping stage directly downstream of the player movement, collision and cannon logic; consumes their attack, block and collision flags.
- Maintains both players' health and runs the round state machine (idle, fight, KO, done).
- Drives health bars and winner/freeze flags consumed by the colour mapper and HEX display path.
- Runs on the 50 MHz board clock; game logic advances once per frame tick derived from VGA_VS.

---
 rtl/fight_health_tracker_if.sv | 31 +++
 rtl/fight_health_tracker.sv | 171 +++++++++++++++++
 tb/tb_fight_health_tracker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fight_health_tracker_if.sv
// Game-flag / status bundle between the movement+collision logic and the
// round/health tracker. master = upstream flag source, slave = tracker.
interface fight_health_tracker_if #(
  parameter int HW = 7
);
  logic          start;
  logic          collision;
  logic          punch, kick, crouchpunch;
  logic          punch2, kick2, crouchpunch2;
  logic          block, block2;
  logic          ballcollision, ballcollision2;
  logic [HW-1:0] health1, health2;
  logic [1:0]    state;
  logic [1:0]    winner;
  logic          freeze;
  logic          game_over;

  modport master (
    output start, collision, punch, kick, crouchpunch,
           punch2, kick2, crouchpunch2, block, block2,
           ballcollision, ballcollision2,
    input  health1, health2, state, winner, freeze, game_over
  );

  modport slave (
    input  start, collision, punch, kick, crouchpunch,
           punch2, kick2, crouchpunch2, block, block2,
           ballcollision, ballcollision2,
    output health1, health2, state, winner, freeze, game_over
  );
endinterface

// File: rtl/fight_health_tracker.sv
// Round/health bookkeeping: per-player health with i-frames, chip damage and
// saturating subtraction, plus the IDLE/FIGHT/KO/DONE round machine. Game
// logic advances once per frame tick taken from the synchronised VGA_VS edge.
// Optional passive regen is built in when HEALTH_REGEN_EN is defined.
module fight_health_tracker #(
  parameter int HW           = 7,
  parameter int MAX_HEALTH   = 100,
  parameter int MELEE_DMG    = 5,
  parameter int BALL_DMG     = 10,
  parameter int CHIP_DMG     = 1,
  parameter int IFRAMES      = 30,
  parameter int KO_FRAMES    = 180,
  parameter int REGEN_FRAMES = 120
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  fight_health_tracker_if.slave  bus
);
  localparam int NP = 2;  // index 0 = P1, 1 = P2
  localparam int IW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
  localparam int KW = (KO_FRAMES > 0) ? $clog2(KO_FRAMES + 1) : 1;
  localparam logic [HW-1:0] MAX_H   = HW'(MAX_HEALTH);
  localparam logic [HW-1:0] MELEE_W = HW'(MELEE_DMG);
  localparam logic [HW-1:0] BALL_W  = HW'(BALL_DMG);
  localparam logic [HW-1:0] CHIP_W  = HW'(CHIP_DMG);
  localparam logic [IW-1:0] IF_LOAD = IW'(IFRAMES);
  localparam logic [KW-1:0] KO_LOAD = KW'(KO_FRAMES);
  localparam bit CFG_OK = (MAX_HEALTH < (2 ** HW)) && (MAX_HEALTH > 0) &&
                          (KO_FRAMES > 0) && (REGEN_FRAMES > 0) &&
                          (IFRAMES >= 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIGHT = 2'd1,
    S_KO    = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [NP-1:0][HW-1:0]   health_q, health_nx;
  logic [NP-1:0][IW-1:0]   iframe_q, iframe_nx;
  logic [NP-1:0]           melee_hit, ball_hit, blk, take, dead;
  logic [KW-1:0]           ko_cnt;
  logic [1:0]              winner_q;
  logic                    freeze_q, game_over_q;
  logic                    fs1, fs2, fs3;
  logic                    tick;

  // One-cycle pulse on the synchronised rising edge of frame_clk.
  assign tick = fs2 & ~fs3;

  // Incoming hits per victim: P1 is hit by P2's attacks and vice versa.
  assign melee_hit[0] = bus.collision & (bus.punch2 | bus.kick2 | bus.crouchpunch2);
  assign melee_hit[1] = bus.collision & (bus.punch  | bus.kick  | bus.crouchpunch);
  assign ball_hit     = {bus.ballcollision, bus.ballcollision2};
  assign blk          = {bus.block2, bus.block};

  for (genvar p = 0; p < NP; p++) begin : g_plr
    logic [HW-1:0] dmg, h_dmg;

    // A hit only lands when the victim's i-frame window has expired.
    assign take[p] = (melee_hit[p] | ball_hit[p]) && (iframe_q[p] == '0);
    // Blocking overrides the hit type; a ball beats melee on the same tick.
    assign dmg     = blk[p] ? CHIP_W : (ball_hit[p] ? BALL_W : MELEE_W);
    assign h_dmg   = !take[p]              ? health_q[p] :
                     (health_q[p] > dmg)   ? health_q[p] - dmg : '0;
    assign iframe_nx[p] = take[p]               ? IF_LOAD :
                          (iframe_q[p] != '0)   ? iframe_q[p] - 1'b1 : '0;
    assign dead[p] = (health_nx[p] == '0);

`ifdef HEALTH_REGEN_EN
    localparam int RW = $clog2(REGEN_FRAMES + 1);
    logic [RW-1:0] regen_cnt;
    logic          regen_due;

    // Regen fires on the tick where the undamaged-streak count would reach
    // REGEN_FRAMES; health < MAX keeps the +1 from overshooting.
    assign regen_due = (state_q == S_FIGHT) && !take[p] &&
                       (health_q[p] < MAX_H) &&
                       (regen_cnt == RW'(REGEN_FRAMES - 1));
    assign health_nx[p] = regen_due ? health_q[p] + 1'b1 : h_dmg;

    // Undamaged-tick streak counter; only runs inside a round.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        regen_cnt <= '0;
      end else if (tick) begin
        if (state_q != S_FIGHT || take[p] || regen_due) regen_cnt <= '0;
        else if (health_q[p] < MAX_H)                     regen_cnt <= regen_cnt + 1'b1;
      end
    end
`else
    assign health_nx[p] = h_dmg;
`endif
  end

  // Frame-edge synchroniser and round state machine with registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs1         <= 1'b0;
      fs2         <= 1'b0;
      fs3         <= 1'b0;
      state_q     <= S_IDLE;
      health_q    <= {NP{MAX_H}};
      iframe_q    <= '0;
      ko_cnt      <= '0;
      winner_q    <= 2'd0;
      freeze_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      fs1 <= frame_clk;
      fs2 <= fs1;
      fs3 <= fs2;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            health_q <= {NP{MAX_H}};
            winner_q <= 2'd0;
            if (bus.start) begin
              state_q  <= S_FIGHT;
              iframe_q <= '0;
            end
          end
          S_FIGHT: begin
            health_q <= health_nx;
            iframe_q <= iframe_nx;
            if (|dead) begin
              // {P1 dead, P2 dead} maps straight onto 1=P1 wins, 2=P2, 3=draw
              winner_q <= {dead[0], dead[1]};
              state_q  <= S_KO;
              ko_cnt   <= KO_LOAD;
              freeze_q <= 1'b1;
            end
          end
          S_KO: begin
            // Leave on the tick that exhausts the count, so KO lasts KO_FRAMES ticks.
            if (ko_cnt <= KW'(1)) begin
              ko_cnt      <= '0;
              state_q     <= S_DONE;
              game_over_q <= 1'b1;
            end else begin
              ko_cnt <= ko_cnt - 1'b1;
            end
          end
          S_DONE: begin
            if (!bus.start) begin
              state_q     <= S_IDLE;
              health_q    <= {NP{MAX_H}};
              winner_q    <= 2'd0;
              freeze_q    <= 1'b0;
              game_over_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.health1   = health_q[0];
  assign bus.health2   = health_q[1];
  assign bus.state     = state_q;
  assign bus.winner    = winner_q;
  assign bus.freeze    = freeze_q;
  assign bus.game_over = game_over_q;

  // Unusable parameter sets trip on the first clock after reset.
  cfg_chk: assert property (@(posedge Clk) disable iff (!Reset_n) CFG_OK);

endmodule

// File: tb/tb_fight_health_tracker.sv
// Bench for fight_health_tracker: table vectors for short cases, hand-written
// sequences for i-frame gating, KO countdown, winners and async reset.
module tb_fight_health_tracker;
  localparam logic [11:0] I_START  = 12'h800, I_COLL   = 12'h400,
                          I_PUNCH  = 12'h200, I_KICK   = 12'h100,
                          I_CPUNCH = 12'h080, I_PUNCH2 = 12'h040,
                          I_KICK2  = 12'h020, I_CPUNCH2= 12'h010,
                          I_BLOCK  = 12'h008, I_BLOCK2 = 12'h004,
                          I_BALL   = 12'h002, I_BALL2  = 12'h001;

  typedef struct {
    string       nm;
    logic [1:0]  st;
    logic [6:0]  h1, h2;
    logic [1:0]  win;
    logic        frz, go;
  } exp_t;

  typedef struct {
    logic [11:0] iv;
    exp_t        e;
  } vec_t;

  logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  int   checks = 0, errors = 0;
  exp_t sb[$];
  vec_t vec[9];
  int   eh1, eh2;

  fight_health_tracker_if bus ();

  fight_health_tracker dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #10 Clk = ~Clk;

  function automatic exp_t mk(string nm, int st, int h1, int h2, int win, int frz, int go);
    exp_t e;
    e.nm = nm; e.st = 2'(st); e.h1 = 7'(h1); e.h2 = 7'(h2);
    e.win = 2'(win); e.frz = 1'(frz); e.go = 1'(go);
    return e;
  endfunction

  task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  task automatic check_outs(exp_t e);
    cmp(e.nm, "state",     32'(bus.state),     32'(e.st));
    cmp(e.nm, "health1",   32'(bus.health1),   32'(e.h1));
    cmp(e.nm, "health2",   32'(bus.health2),   32'(e.h2));
    cmp(e.nm, "winner",    32'(bus.winner),    32'(e.win));
    cmp(e.nm, "freeze",    32'(bus.freeze),    32'(e.frz));
    cmp(e.nm, "game_over", 32'(bus.game_over), 32'(e.go));
  endtask

  task automatic drive(logic [11:0] iv);
    {bus.start, bus.collision, bus.punch, bus.kick, bus.crouchpunch,
     bus.punch2, bus.kick2, bus.crouchpunch2, bus.block, bus.block2,
     bus.ballcollision, bus.ballcollision2} = iv;
  endtask

  // One frame tick: expectation queued with the stimulus, popped once the
  // synchroniser (2 flops) plus the output register have had their edges.
  task automatic do_tick(logic [11:0] iv, exp_t e);
    exp_t got;
    drive(iv);
    sb.push_back(e);
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    got = sb.pop_front();
    check_outs(got);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic run(int n, logic [11:0] iv, exp_t e);
    for (int i = 0; i < n; i++) do_tick(iv, e);
  endtask

  initial begin
    vec[0] = '{12'h000,  mk("idle0",   0, 100, 100, 0, 0, 0)};
    vec[1] = '{12'h000,  mk("idle1",   0, 100, 100, 0, 0, 0)};
    vec[2] = '{12'h000,  mk("idle2",   0, 100, 100, 0, 0, 0)};
    vec[3] = '{I_START,  mk("start",   1, 100, 100, 0, 0, 0)};
    vec[4] = '{12'h000,  mk("startlo", 1, 100, 100, 0, 0, 0)};
    vec[5] = '{I_BALL | I_COLL | I_KICK | I_BLOCK2, mk("chip",    1, 100, 89, 0, 0, 0)};
    vec[6] = '{I_BALL,                              mk("ifr_bal", 1, 100, 89, 0, 0, 0)};
    vec[7] = '{I_COLL | I_CPUNCH2,                  mk("cpunch2", 1, 95,  89, 0, 0, 0)};
    vec[8] = '{I_COLL | I_PUNCH2 | I_BLOCK,         mk("ifr_p1",  1, 95,  89, 0, 0, 0)};

    drive(12'h000);
    repeat (3) @(posedge Clk);
    #1;
    check_outs(mk("reset", 0, 100, 100, 0, 0, 0));
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    for (int i = 0; i < 5; i++) do_tick(vec[i].iv, vec[i].e);

    // Held punch with contact: hit, 30 gated ticks, second hit on tick 32.
    for (int t = 1; t <= 40; t++)
      do_tick(I_COLL | I_PUNCH, mk($sformatf("melee%0d", t), 1, 100, (t < 32) ? 95 : 90, 0, 0, 0));
    run(30, 12'h000, mk("quiet_a", 1, 100, 90, 0, 0, 0));

    for (int i = 5; i < 9; i++) do_tick(vec[i].iv, vec[i].e);
    run(31, 12'h000, mk("quiet_b", 1, 95, 89, 0, 0, 0));

    // Grind both players down to 3 / 5 with ball and chip hits.
    eh1 = 95; eh2 = 89;
    for (int r = 0; r < 12; r++) begin
      logic [11:0] iv;
      iv = 12'h000;
      if (r < 9)       begin iv |= I_BALL2;           eh1 -= 10; end
      else if (r < 11) begin iv |= I_BALL2 | I_BLOCK; eh1 -= 1;  end
      if (r < 8)       begin iv |= I_BALL;            eh2 -= 10; end
      else             begin iv |= I_BALL | I_BLOCK2; eh2 -= 1;  end
      do_tick(iv, mk($sformatf("grind%0d", r), 1, eh1, eh2, 0, 0, 0));
      run(30, 12'h000, mk("grind_q", 1, eh1, eh2, 0, 0, 0));
    end

    // Simultaneous fireballs: both saturate to 0 -> draw.
    do_tick(I_BALL | I_BALL2, mk("ko_draw", 2, 0, 0, 3, 1, 0));
    run(179, I_START | I_BALL | I_BALL2 | I_COLL | I_PUNCH, mk("ko_wait", 2, 0, 0, 3, 1, 0));
    do_tick(I_START, mk("done",      3, 0, 0, 3, 1, 1));
    do_tick(I_START, mk("done_hold", 3, 0, 0, 3, 1, 1));
    do_tick(12'h000, mk("to_idle",   0, 100, 100, 0, 0, 0));

    // Second round: P1 knocked out alone -> P2 wins.
    do_tick(I_START, mk("start2", 1, 100, 100, 0, 0, 0));
    eh1 = 100;
    for (int r = 0; r < 10; r++) begin
      eh1 -= 10;
      if (r < 9) begin
        do_tick(I_BALL2, mk($sformatf("p2win%0d", r), 1, eh1, 100, 0, 0, 0));
        run(30, 12'h000, mk("p2win_q", 1, eh1, 100, 0, 0, 0));
      end else begin
        do_tick(I_BALL2, mk("ko_p2", 2, 0, 100, 2, 1, 0));
      end
    end
    run(5, 12'h000, mk("ko2_wait", 2, 0, 100, 2, 1, 0));

    // Async reset mid-KO, away from any clock edge.
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_outs(mk("async_rst", 0, 100, 100, 0, 0, 0));
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    do_tick(12'h000, mk("post_rst", 0, 100, 100, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
